// File: rtl/compuerta_logica_seq.sv
// Registered ANCHO-bit logic stage with valid/ready and burst accumulate.
// Optional even-parity output p enabled by defining COMPUERTA_PARIDAD_EN.
module compuerta_logica_seq #(
    parameter int ANCHO    = 8,
    parameter int CUENTA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ANCHO-1:0]    a,
    input  logic [ANCHO-1:0]    b,
    input  logic [2:0]          op,
    input  logic                acum,
    input  logic                ultimo,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ANCHO-1:0]    f,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef COMPUERTA_PARIDAD_EN
    output logic [CUENTA_W-1:0] cuenta,
    output logic                p
`else
    output logic [CUENTA_W-1:0] cuenta
`endif
);

    typedef enum logic {IDLE, ACUM} estado_t;

    estado_t             state_q;
    logic [ANCHO-1:0]    f_q;
    logic [ANCHO-1:0]    acc_q;
    logic [CUENTA_W-1:0] cuenta_q;
    logic [CUENTA_W-1:0] cnt_q;
    logic [2:0]          op_q;
    logic                out_valid_q;

    logic                acepta_d;
    logic [2:0]          op_sel_d;
    logic [ANCHO-1:0]    r_d;
    logic [ANCHO-1:0]    fold_d;
    logic [CUENTA_W-1:0] cnt_inc_d;

    assign in_ready = !out_valid_q || out_ready;
    assign acepta_d = in_valid && in_ready;

    // Inside a burst the operation comes from the latched op, not the port
    assign op_sel_d = (state_q == ACUM) ? op_q : op;

    always_comb begin
        r_d = '0;
        unique case (op_sel_d)
            3'b000:  r_d = a & b;
            3'b001:  r_d = a | b;
            3'b010:  r_d = a ^ b;
            3'b011:  r_d = ~(a & b);
            3'b100:  r_d = ~(a | b);
            3'b101:  r_d = ~(a ^ b);
            3'b110:  r_d = ~a;
            default: r_d = a;
        endcase
    end

    always_comb begin
        fold_d = r_d;
        unique case (op_q)
            3'b000, 3'b011: fold_d = acc_q & r_d;
            3'b001, 3'b100: fold_d = acc_q | r_d;
            3'b010, 3'b101: fold_d = acc_q ^ r_d;
            default:        fold_d = r_d;
        endcase
    end

    assign cnt_inc_d = (cnt_q == '1) ? cnt_q : cnt_q + CUENTA_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            f_q         <= '0;
            acc_q       <= '0;
            cuenta_q    <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (acepta_d) begin
                unique case (state_q)
                    IDLE: begin
                        if (!acum || ultimo) begin
                            f_q         <= r_d;
                            cuenta_q    <= CUENTA_W'(1);
                            out_valid_q <= 1'b1;
                        end else begin
                            acc_q   <= r_d;
                            cnt_q   <= CUENTA_W'(1);
                            op_q    <= op;
                            state_q <= ACUM;
                        end
                    end
                    default: begin
                        if (ultimo) begin
                            f_q         <= fold_d;
                            cuenta_q    <= cnt_inc_d;
                            out_valid_q <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            acc_q <= fold_d;
                            cnt_q <= cnt_inc_d;
                        end
                    end
                endcase
            end
        end
    end

`ifdef COMPUERTA_PARIDAD_EN
    logic p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= 1'b0;
        end else if (acepta_d && (state_q == ACUM ? ultimo : (!acum || ultimo))) begin
            p_q <= (state_q == ACUM) ? ^fold_d : ^r_d;
        end
    end

    assign p = p_q;
`endif

    assign f         = f_q;
    assign out_valid = out_valid_q;
    assign cuenta    = cuenta_q;

endmodule

// File: tb/tb_compuerta_logica_seq.sv
// Directed self-checking bench for compuerta_logica_seq.
// Covers reset, all ops, bursts, backpressure, async reset, saturation.
module tb_compuerta_logica_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acum;
    logic       ultimo;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] f;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] cuenta;
`ifdef COMPUERTA_PARIDAD_EN
    logic       p;
`endif

    int tests;
    int fails;

    compuerta_logica_seq #(.ANCHO(8), .CUENTA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .acum      (acum),
        .ultimo    (ultimo),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef COMPUERTA_PARIDAD_EN
        .cuenta    (cuenta),
        .p         (p)
`else
        .cuenta    (cuenta)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp3 [8];

    initial begin
        tests = 0;
        fails = 0;
        exp3[0] = 8'h05; exp3[1] = 8'hAF; exp3[2] = 8'hAA; exp3[3] = 8'hFA;
        exp3[4] = 8'h50; exp3[5] = 8'h55; exp3[6] = 8'h5A; exp3[7] = 8'hA5;

        rst_n = 1'b0; a = '0; b = '0; op = '0; acum = 1'b0;
        ultimo = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_f", f, 8'h00);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_cuenta", cuenta, 8'h00);
        chk("rst_ready", in_ready, 1'b1);
`ifdef COMPUERTA_PARIDAD_EN
        chk("rst_p", p, 1'b0);
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("idle_ov", out_valid, 1'b0);

        // single AND beat
        op = 3'b000; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("and_f", f, 8'h30);
        chk("and_ov", out_valid, 1'b1);
        chk("and_cuenta", cuenta, 8'h01);
        tick();
        chk("and_ov_drop", out_valid, 1'b0);

        // all eight ops back to back
        a = 8'hA5; b = 8'h0F; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            chk($sformatf("op%0d_f", i), f, exp3[i]);
            chk($sformatf("op%0d_ov", i), out_valid, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("ops_ov_drop", out_valid, 1'b0);

        // XOR burst; op/acum changed mid-burst must be ignored
        acum = 1'b1; op = 3'b010; a = 8'h01; b = 8'h00; in_valid = 1'b1;
        tick();
        chk("xb1_ov", out_valid, 1'b0);
        acum = 1'b0; op = 3'b000; a = 8'h02;
        tick();
        chk("xb2_ov", out_valid, 1'b0);
        a = 8'h04; ultimo = 1'b1;
        tick();
        chk("xb_f", f, 8'h07);
        chk("xb_cuenta", cuenta, 8'h03);
        chk("xb_ov", out_valid, 1'b1);
        in_valid = 1'b0; ultimo = 1'b0;
        tick();

        // NAND burst folded with AND
        acum = 1'b1; op = 3'b011; a = 8'hFF; b = 8'h0F; in_valid = 1'b1;
        tick();
        chk("nb1_ov", out_valid, 1'b0);
        b = 8'h3F; ultimo = 1'b1;
        tick();
        chk("nb_f", f, 8'hC0);
        chk("nb_cuenta", cuenta, 8'h02);
        in_valid = 1'b0; ultimo = 1'b0; acum = 1'b0;

        // backpressure
        out_ready = 1'b0;
        #1;
        chk("bp_ready", in_ready, 1'b0);
        op = 3'b111; a = 8'h11; b = 8'h00; in_valid = 1'b1;
        tick();
        chk("bp_f_hold1", f, 8'hC0);
        chk("bp_ov_hold1", out_valid, 1'b1);
        tick();
        chk("bp_f_hold2", f, 8'hC0);
        chk("bp_cuenta_hold", cuenta, 8'h02);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_up", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_f_new", f, 8'h11);
        chk("bp_ov_new", out_valid, 1'b1);
        chk("bp_cuenta_new", cuenta, 8'h01);
        tick();
        chk("bp_ov_drop", out_valid, 1'b0);

        // async reset in the middle of an XOR burst
        acum = 1'b1; op = 3'b010; a = 8'h03; b = 8'h00; in_valid = 1'b1;
        tick();
        a = 8'h04;
        tick();
        in_valid = 1'b0; acum = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ov", out_valid, 1'b0);
        chk("ar_f", f, 8'h00);
        chk("ar_cuenta", cuenta, 8'h00);
        #1 rst_n = 1'b1;
        op = 3'b001; a = 8'h0F; b = 8'h00; in_valid = 1'b1;
        tick();
        chk("ar_or_f", f, 8'h0F);
        chk("ar_or_cuenta", cuenta, 8'h01);
`ifdef COMPUERTA_PARIDAD_EN
        chk("par_0f", p, 1'b0);
`endif
        op = 3'b111; a = 8'h07;
        tick();
        chk("pass_07", f, 8'h07);
`ifdef COMPUERTA_PARIDAD_EN
        chk("par_07", p, 1'b1);
`endif
        in_valid = 1'b0;
        tick();

        // long replace burst: beat counter saturates at 255
        acum = 1'b1; op = 3'b111; b = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 299; i++) begin
            a = 8'(i);
            tick();
        end
        chk("sat_ov_quiet", out_valid, 1'b0);
        a = 8'h5A; ultimo = 1'b1;
        tick();
        in_valid = 1'b0; ultimo = 1'b0; acum = 1'b0;
        chk("sat_f", f, 8'h5A);
        chk("sat_cuenta", cuenta, 8'hFF);
        chk("sat_ov", out_valid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
